// File: rtl/sseg_pkg.sv
// +----------------------------------------------------------------------------
// | Module  : sseg_pkg
// | Brief   : Shared constants and debounce state type for the sseg I/O feeder.
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

package sseg_pkg;

  localparam logic [31:0] SSEG_ADDR_DEF = 32'h1100_00C0;
  localparam logic [31:0] MODE_ADDR_DEF = 32'h1100_00C4;
  localparam logic [15:0] BCD_MAX       = 16'd9999;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } dbnc_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce_pulse.sv
// +----------------------------------------------------------------------------
// | Module  : btn_debounce_pulse
// | Brief   : Synchronises and debounces a push-button, one-cycle pulse per press.
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module btn_debounce_pulse
  import sseg_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_IN,
  output logic PULSE_OUT
);

  localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  c_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_btn_s;
  dbnc_state_t      r_state;
  dbnc_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= BTN_IN;
      r_btn_s <= r_sync1;
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Pulse is issued on the same cycle the FSM commits to PRESSED
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    PULSE_OUT   = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_btn_s) begin
          w_state_nxt = WAIT_PRESS;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_PRESS: begin
        if (!r_btn_s) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = PRESSED;
          PULSE_OUT   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      PRESSED: begin
        if (!r_btn_s) begin
          w_state_nxt = WAIT_RELEASE;
          w_cnt_nxt   = '0;
        end
      end
      WAIT_RELEASE: begin
        if (r_btn_s) begin
          w_state_nxt = PRESSED;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt + c_CNT_ONE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/sseg_io_ctrl.sv
// +----------------------------------------------------------------------------
// | Module  : sseg_io_ctrl
// | Brief   : I/O-bus register front end for the seven-segment display.
// | Revision: 1.0 - initial release
// +----------------------------------------------------------------------------
`default_nettype none

module sseg_io_ctrl
  import sseg_pkg::*;
#(
  parameter logic [31:0] SSEG_ADDR       = SSEG_ADDR_DEF,
  parameter logic [31:0] MODE_ADDR       = MODE_ADDR_DEF,
  parameter int          DEBOUNCE_CYCLES = 500_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  input  logic        BTN_MODE,
  output logic [15:0] DATA_OUT,
  output logic        MODE_OUT,
  output logic        OVF
);

  logic        w_wr_sseg;
  logic        w_wr_mode;
  logic        w_toggle;
  logic [15:0] r_data;
  logic        r_mode;
  logic        w_unused_bus_hi;

  assign w_wr_sseg       = IOBUS_WR && (IOBUS_ADDR == SSEG_ADDR);
  assign w_wr_mode       = IOBUS_WR && (IOBUS_ADDR == MODE_ADDR);
  assign w_unused_bus_hi = ^IOBUS_OUT[31:16];

  btn_debounce_pulse #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce_pulse (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_IN    (BTN_MODE),
    .PULSE_OUT (w_toggle)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_data <= '0;
    end else if (w_wr_sseg) begin
      r_data <= IOBUS_OUT[15:0];
    end
  end

  // An explicit software write overrides a coincident button toggle
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_mode <= 1'b0;
    end else if (w_wr_mode) begin
      r_mode <= IOBUS_OUT[0];
    end else if (w_toggle) begin
      r_mode <= ~r_mode;
    end
  end

  assign DATA_OUT = r_data;
  assign MODE_OUT = r_mode;
  assign OVF      = r_mode && (r_data > BCD_MAX);

endmodule

`default_nettype wire
